// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-engine state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry valid/ready buffer; input ready depends only on fill level.
module axi_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign in_rdy_o   = (cnt_q != 2'd2);
    assign out_vld_o  = (cnt_q != 2'd0);
    assign out_data_o = mem_q[rd_q];
    assign push       = in_vld_i & in_rdy_o;
    assign pop        = out_vld_o & out_rdy_i;

    // Pointer and occupancy update.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = ~wr_q;
        if (pop)  rd_d = ~rd_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers with synchronous reset (flushes the buffer).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data_i;
    end

endmodule

// File: rtl/axi_rd_stride_engine.sv
// Splits one strided LSU load into AXI read bursts with per-burst ARIDs
// and returns R beats tagged with their transaction index.
module axi_rd_stride_engine
    import axi_pkg::*;
#(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_OUTS = 4,
    parameter int unsigned NUM_W    = 8,
    parameter int unsigned STR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [STR_W-1:0]  cmd_stride,
    input  logic [NUM_W-1:0]  cmd_num,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic              lsu_rvld,
    input  logic              lsu_rrdy,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [NUM_W-1:0]  lsu_ridx,
    output logic              lsu_rlast,
    output logic              done,
    output logic [1:0]        done_resp
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [NUM_W-1:0]  idx;
        logic              last;
    } rbeat_t;

    localparam int unsigned BEAT_W = $bits(rbeat_t);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STR_W-1:0]  stride_q, stride_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [NUM_W-1:0]  issued_q, issued_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              arvld_q, arvld_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [1:0]        resp_q, resp_d;
    logic              done_c;

    logic [MAX_OUTS-1:0] tvld_q, tvld_d;
    logic [NUM_W-1:0]    tidx_q [MAX_OUTS];
    logic [NUM_W-1:0]    tidx_d [MAX_OUTS];

    logic              ar_fire, r_fire, rid_hit;
    logic [NUM_W-1:0]  hit_idx;
    logic              nxt_any;
    logic [ID_W-1:0]   nxt_id;
    logic              sk_in_rdy, sk_out_vld;
    rbeat_t            sk_in, sk_out;

    assign ar_fire = arvld_q & ARREADY;
    assign r_fire  = RVALID & RREADY;

    assign cmd_rdy   = (state_q == ST_IDLE);
    assign ARID      = arid_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARBURST   = burst_q;
    assign ARVALID   = arvld_q;
    assign RREADY    = sk_in_rdy;
    assign lsu_rvld  = sk_out_vld;
    assign lsu_rdata = sk_out.data;
    assign lsu_ridx  = sk_out.idx;
    assign lsu_rlast = sk_out.last;
    assign done      = done_c;
    assign done_resp = resp_q;

    // RID lookup: hit only on a live table entry; RIDs beyond the table miss.
    always_comb begin
        rid_hit = 1'b0;
        hit_idx = '0;
        for (int e = 0; e < MAX_OUTS; e++) begin
            if (RID == ID_W'(e) && tvld_q[e]) begin
                rid_hit = 1'b1;
                hit_idx = tidx_q[e];
            end
        end
    end

    // ID table: allocate on AR handshake, free on RLAST of a live entry.
    always_comb begin
        tvld_d = tvld_q;
        tidx_d = tidx_q;
        for (int e = 0; e < MAX_OUTS; e++) begin
            if (state_q == ST_ISSUE && ar_fire && arid_q == ID_W'(e)) begin
                tvld_d[e] = 1'b1;
                tidx_d[e] = issued_q;
            end
            if (r_fire && rid_hit && RLAST && RID == ID_W'(e)) begin
                tvld_d[e] = 1'b0;
            end
        end
    end

    // Lowest free entry as seen after this cycle's table updates.
    always_comb begin
        nxt_any = 1'b0;
        nxt_id  = '0;
        for (int e = MAX_OUTS - 1; e >= 0; e--) begin
            if (!tvld_d[e]) begin
                nxt_any = 1'b1;
                nxt_id  = ID_W'(e);
            end
        end
    end

    // Engine FSM: latch command, issue ARs via address accumulator, drain R.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        num_d    = num_q;
        issued_d = issued_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        arvld_d  = arvld_q;
        arid_d   = arid_q;
        done_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    state_d  = ST_ISSUE;
                    addr_d   = cmd_addr;
                    stride_d = cmd_stride;
                    num_d    = (cmd_num == '0) ? NUM_W'(1) : cmd_num;
                    issued_d = '0;
                    len_d    = cmd_len;
                    size_d   = cmd_size;
                    burst_d  = cmd_burst;
                    arvld_d  = nxt_any;
                    arid_d   = nxt_id;
                end
            end
            ST_ISSUE: begin
                if (ar_fire) begin
                    addr_d   = ADDR_W'(addr_q + ADDR_W'(stride_q));
                    issued_d = issued_q + NUM_W'(1);
                    if (issued_q == num_q - NUM_W'(1)) begin
                        state_d = ST_DRAIN;
                        arvld_d = 1'b0;
                    end else begin
                        arvld_d = nxt_any;
                        arid_d  = nxt_id;
                    end
                end else if (!arvld_q) begin
                    arvld_d = nxt_any;
                    arid_d  = nxt_id;
                end
            end
            ST_DRAIN: begin
                if (tvld_q == '0 && !sk_out_vld) begin
                    state_d = ST_IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky worst-case response; unknown RIDs force DECERR.
    always_comb begin
        resp_d = resp_q;
        if (state_q == ST_IDLE && cmd_vld) begin
            resp_d = RESP_OKAY;
        end else if (r_fire) begin
            if (!rid_hit)
                resp_d = RESP_DECERR;
            else if (RRESP > resp_q)
                resp_d = RRESP;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            num_q    <= '0;
            issued_q <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= BURST_INCR;
            arvld_q  <= 1'b0;
            arid_q   <= '0;
            resp_q   <= RESP_OKAY;
            tvld_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            arvld_q  <= arvld_d;
            arid_q   <= arid_d;
            resp_q   <= resp_d;
            tvld_q   <= tvld_d;
        end
    end

    // Table index storage; qualified by the valid bits.
    always_ff @(posedge clk) begin
        tidx_q <= tidx_d;
    end

    assign sk_in = '{data: RDATA, idx: hit_idx, last: RLAST};

    axi_skid_buf #(
        .WIDTH(BEAT_W)
    ) u_r_skid (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (RVALID & rid_hit),
        .in_rdy_o  (sk_in_rdy),
        .in_data_i (sk_in),
        .out_vld_o (sk_out_vld),
        .out_rdy_i (lsu_rrdy),
        .out_data_o(sk_out)
    );

endmodule
